// File: rtl/ddd_chain.sv
// Serial programmer for a daisy chain of 3D3444-class delay chips: write, latch, read back, retry.
// Optional first-mismatch capture ports are enabled with `define DDD_CHAIN_FAIL_CAPTURE_EN.
module ddd_chain #(
    parameter int NCHIPS = 2,
    parameter int NCH    = 4,
    parameter int DBITS  = 4,
    localparam int FBITS = 4 + NCH*DBITS,
    localparam int NBITS = NCHIPS*FBITS,
    localparam int IBITS = $clog2(NBITS)
) (
    input  logic                         clock,
    input  logic                         global_reset,
    input  logic                         power_up,
    input  logic                         vme_ready,
    input  logic                         start,
    input  logic                         autostart_en,
    input  logic [4*NCHIPS-1:0]          oe,
    input  logic [NCHIPS*NCH*DBITS-1:0]  delay,
    input  logic [1:0]                   verify_dly,
    input  logic [1:0]                   max_retry,
    output logic                         serial_clock,
    output logic                         serial_out,
    output logic                         adr_latch,
    input  logic                         serial_in,
    output logic                         busy,
    output logic                         verify_ok,
    output logic [1:0]                   retry_cnt
`ifdef DDD_CHAIN_FAIL_CAPTURE_EN
    ,
    output logic [IBITS-1:0]             first_err_bit,
    output logic                         err_valid
`endif
);

    typedef enum logic [3:0] {
        S_WAIT_FPGA, S_WAIT_POWERUP, S_IDLE, S_INIT, S_WRITE,
        S_LATCH, S_VERIFY, S_CHECK, S_UNSTART
    } state_t;

    state_t             state, state_nx;
    logic               power_up_ff, vme_ready_ff, start_ff, autostart_ff;
    logic               half;
    logic [IBITS-1:0]   bit_cnt;
    logic [NBITS-1:0]   sr, frame;
    logic               serial_in_ff, cmp_ok;
    logic [3:0]         chk_pipe, exp_pipe;
    logic               shifting, done, strobe, mismatch;
    logic [1:0]         retry_nx;
    logic               vok_nx;

    // Chip NCHIPS-1 sits in the top of the shift register so it leaves first.
    always_comb begin
        frame = '0;
        for (int k = 0; k < NCHIPS; k++) begin
            frame[k*FBITS + NCH*DBITS +: 4] = oe[4*k +: 4];
            for (int c = 0; c < NCH; c++)
                frame[k*FBITS + (NCH-1-c)*DBITS +: DBITS] = delay[(k*NCH+c)*DBITS +: DBITS];
        end
    end

    assign shifting = (state == S_WRITE) || (state == S_VERIFY);
    assign done     = shifting && half && (bit_cnt == IBITS'(NBITS-1));
    assign strobe   = (state == S_VERIFY) && half;
    // Pipe stage 0 already lines up with serial_in_ff; verify_dly adds whole clocks on top.
    assign mismatch = chk_pipe[verify_dly] && (exp_pipe[verify_dly] != serial_in_ff);

    always_comb begin
        state_nx = state;
        retry_nx = retry_cnt;
        vok_nx   = verify_ok;
        case (state)
            S_WAIT_FPGA:    if (power_up_ff) state_nx = S_WAIT_POWERUP;
            S_WAIT_POWERUP: if (vme_ready_ff) begin
                                state_nx = autostart_ff ? S_INIT : S_IDLE;
                                retry_nx = 2'd0;
                            end
            S_IDLE:         if (start_ff) begin
                                state_nx = S_INIT;
                                retry_nx = 2'd0;
                            end
            S_INIT:         begin
                                state_nx = S_WRITE;
                                vok_nx   = 1'b0;
                            end
            S_WRITE:        if (done) state_nx = S_LATCH;
            S_LATCH:        state_nx = S_VERIFY;
            S_VERIFY:       if (done) state_nx = S_CHECK;
            // Decide only once every delayed compare strobe has drained.
            S_CHECK:        if (chk_pipe == 4'd0) begin
                                if (cmp_ok) begin
                                    vok_nx   = 1'b1;
                                    state_nx = S_UNSTART;
                                end else if (retry_cnt < max_retry) begin
                                    retry_nx = 2'(retry_cnt + 2'd1);
                                    state_nx = S_INIT;
                                end else begin
                                    state_nx = S_UNSTART;
                                end
                            end
            S_UNSTART:      if (!start_ff) state_nx = S_IDLE;
            default:        state_nx = S_WAIT_FPGA;
        endcase
    end

    always_ff @(posedge clock) begin
        if (global_reset) begin
            state        <= S_WAIT_FPGA;
            power_up_ff  <= 1'b0;
            vme_ready_ff <= 1'b0;
            start_ff     <= 1'b0;
            autostart_ff <= 1'b0;
            half         <= 1'b0;
            bit_cnt      <= '0;
            sr           <= '0;
            serial_clock <= 1'b0;
            serial_out   <= 1'b0;
            adr_latch    <= 1'b1;
            busy         <= 1'b0;
            verify_ok    <= 1'b0;
            retry_cnt    <= 2'd0;
            serial_in_ff <= 1'b0;
            chk_pipe     <= 4'd0;
            exp_pipe     <= 4'd0;
            cmp_ok       <= 1'b0;
        end else begin
            power_up_ff  <= power_up;
            vme_ready_ff <= vme_ready;
            start_ff     <= start;
            autostart_ff <= autostart_en;
            state        <= state_nx;
            retry_cnt    <= retry_nx;
            verify_ok    <= power_up_ff & vok_nx;
            half         <= shifting ? ~half : 1'b0;
            if (!shifting)
                bit_cnt <= '0;
            else if (half)
                bit_cnt <= done ? '0 : IBITS'(bit_cnt + 1'b1);
            if (state == S_INIT || state == S_LATCH)
                sr <= frame;
            else if (shifting && half)
                sr <= {sr[NBITS-2:0], 1'b0};
            serial_clock <= power_up_ff & half;
            serial_out   <= power_up_ff & shifting & sr[NBITS-1];
            adr_latch    <= ~(power_up_ff && state == S_LATCH);
            busy         <= power_up_ff && (state != S_IDLE);
            serial_in_ff <= serial_in;
            chk_pipe     <= {chk_pipe[2:0], strobe};
            exp_pipe     <= {exp_pipe[2:0], sr[NBITS-1]};
            if (state == S_INIT)
                cmp_ok <= 1'b1;
            else if (mismatch)
                cmp_ok <= 1'b0;
        end
    end

`ifdef DDD_CHAIN_FAIL_CAPTURE_EN
    logic [IBITS-1:0] idx_pipe [4];

    always_ff @(posedge clock) begin
        if (global_reset) begin
            for (int i = 0; i < 4; i++) idx_pipe[i] <= '0;
            first_err_bit <= '0;
            err_valid     <= 1'b0;
        end else begin
            idx_pipe[0] <= bit_cnt;
            for (int i = 1; i < 4; i++) idx_pipe[i] <= idx_pipe[i-1];
            if (state == S_INIT) begin
                first_err_bit <= '0;
                err_valid     <= 1'b0;
            end else if (mismatch && !err_valid) begin
                first_err_bit <= idx_pipe[verify_dly];
                err_valid     <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ddd_chain.sv
// Bench for ddd_chain: loopback chip model, bit-stream and status scoreboard, reset/start corner cases.
module tb_ddd_chain;
    localparam int NCHIPS = 2;
    localparam int NCH    = 4;
    localparam int DBITS  = 4;
    localparam int FBITS  = 4 + NCH*DBITS;
    localparam int NBITS  = NCHIPS*FBITS;

    logic clock = 1'b0;
    logic global_reset, power_up, vme_ready, start, autostart_en;
    logic [4*NCHIPS-1:0] oe;
    logic [NCHIPS*NCH*DBITS-1:0] delay;
    logic [1:0] verify_dly, max_retry, retry_cnt;
    logic serial_clock, serial_out, adr_latch, serial_in, busy, verify_ok;
`ifdef DDD_CHAIN_FAIL_CAPTURE_EN
    logic [$clog2(NBITS)-1:0] first_err_bit;
    logic err_valid;
`endif

    ddd_chain #(.NCHIPS(NCHIPS), .NCH(NCH), .DBITS(DBITS)) dut (
        .clock(clock), .global_reset(global_reset), .power_up(power_up),
        .vme_ready(vme_ready), .start(start), .autostart_en(autostart_en),
        .oe(oe), .delay(delay), .verify_dly(verify_dly), .max_retry(max_retry),
        .serial_clock(serial_clock), .serial_out(serial_out), .adr_latch(adr_latch),
        .serial_in(serial_in), .busy(busy), .verify_ok(verify_ok), .retry_cnt(retry_cnt)
`ifdef DDD_CHAIN_FAIL_CAPTURE_EN
        , .first_err_bit(first_err_bit), .err_valid(err_valid)
`endif
    );

    // clock / reset
    always #5 clock = ~clock;

    // scoreboard state
    logic [0:0]  exp_bit_q[$];
    logic [15:0] exp_stat_q[$];
    int n_vec = 0;
    int n_err = 0;

    // loopback chip model: serial_out delayed lb_d clocks, optionally faulted
    int lb_d = 1;
    int fault = 0;
    int lat_cnt = 0;
    int lat_w = 0;
    int vrise = 0;
    logic [3:0] hist = 4'd0;
    always @(posedge clock) hist <= {hist[2:0], serial_out};
    always_comb begin
        serial_in = (lb_d == 0) ? serial_out : hist[lb_d-1];
        if (fault == 1)
            serial_in = 1'b0;
        else if (fault == 2 && lat_cnt == 1 && vrise >= 6 && vrise <= 8)
            serial_in = ~serial_in;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: pops expected bits on serial_clock rises, status on busy falling
    logic sc_prev = 1'b0, al_prev = 1'b1, busy_prev = 1'b0;
    always @(negedge clock) begin
        logic [0:0]  b;
        logic [15:0] st;
        if (serial_clock && !sc_prev) begin
            vrise++;
            if (exp_bit_q.size() == 0)
                chk("unexpected_shift", 32'(serial_clock), 32'd0);
            else begin
                b = exp_bit_q.pop_front();
                chk("serial_out_bit", 32'(serial_out), 32'(b));
            end
        end
        if (!adr_latch) begin
            lat_cnt++;
            lat_w++;
            vrise = 0;
        end
        if (adr_latch && !al_prev) begin
            chk("adr_latch_width", 32'(lat_w), 32'd1);
            lat_w = 0;
        end
        if (!busy && busy_prev) begin
            if (lat_cnt > 0) begin
                if (exp_stat_q.size() == 0)
                    chk("unexpected_done", 32'(lat_cnt), 32'd0);
                else begin
                    st = exp_stat_q.pop_front();
                    chk("attempts", 32'(lat_cnt), 32'(st[2:0]));
                    chk("verify_ok", 32'(verify_ok), 32'(st[3]));
                    chk("retry_cnt", 32'(retry_cnt), 32'(st[5:4]));
                    chk("bits_left", 32'(exp_bit_q.size()), 32'd0);
`ifdef DDD_CHAIN_FAIL_CAPTURE_EN
                    if (st[6]) begin
                        chk("err_valid", 32'(err_valid), 32'(st[7]));
                        if (st[7]) chk("first_err_bit", 32'(first_err_bit), 32'(st[13:8]));
                    end
`endif
                end
            end
            lat_cnt = 0;
            vrise = 0;
        end
        sc_prev = serial_clock;
        al_prev = adr_latch;
        busy_prev = busy;
    end

    // reference model: frame in transmission order plus attempt outcome
    task automatic push_expect(input int fm, input int mr);
        logic fb [NBITS];
        int n, first1, att, rc;
        logic ok;
        logic [15:0] st;
        n = 0;
        for (int k = NCHIPS-1; k >= 0; k--) begin
            for (int b = 3; b >= 0; b--) fb[n++] = oe[4*k+b];
            for (int c = 0; c < NCH; c++)
                for (int b = DBITS-1; b >= 0; b--) fb[n++] = delay[(k*NCH+c)*DBITS+b];
        end
        first1 = -1;
        for (int i = NBITS-1; i >= 0; i--) if (fb[i]) first1 = i;
        if (fm == 0 || (fm == 1 && first1 < 0)) begin att = 1; ok = 1'b1; rc = 0; end
        else if (fm == 2 && mr >= 1)           begin att = 2; ok = 1'b1; rc = 1; end
        else if (fm == 2)                      begin att = 1; ok = 1'b0; rc = 0; end
        else                                   begin att = mr + 1; ok = 1'b0; rc = mr; end
        for (int a = 0; a < 2*att; a++)
            for (int i = 0; i < NBITS; i++) exp_bit_q.push_back(fb[i]);
        st = 16'd0;
        st[2:0] = 3'(att);
        st[3] = ok;
        st[5:4] = 2'(rc);
        st[6] = (fm != 2);
        st[7] = (fm == 1 && first1 >= 0);
        st[13:8] = (first1 >= 0) ? 6'(first1) : 6'd0;
        exp_stat_q.push_back(st);
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 4000 && exp_stat_q.size() != 0; i++) @(posedge clock);
        #1;
        if (exp_stat_q.size() != 0) begin
            chk("done_timeout", 32'(exp_stat_q.size()), 32'd0);
            exp_stat_q.delete();
            exp_bit_q.delete();
        end
    endtask

    // driver: one program cycle started by a start edge
    task automatic run_cycle(input logic [7:0] o, input logic [31:0] d, input int dd,
                             input int fm, input int mr, input bit hold);
        oe = o; delay = d; lb_d = dd; verify_dly = 2'(dd); fault = fm; max_retry = 2'(mr);
        push_expect(fm, mr);
        @(posedge clock); #1 start = 1'b1;
        if (!hold) begin
            @(posedge clock); #1 start = 1'b0;
            wait_done();
            repeat (3) @(posedge clock);
        end
    endtask

    initial begin
        int i;
        global_reset = 1'b1; power_up = 1'b0; vme_ready = 1'b0; start = 1'b0;
        autostart_en = 1'b1; oe = 8'h00; delay = 32'd0; verify_dly = 2'd1; max_retry = 2'd0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_serial_clock", 32'(serial_clock), 32'd0);
        chk("rst_serial_out", 32'(serial_out), 32'd0);
        chk("rst_adr_latch", 32'(adr_latch), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_verify_ok", 32'(verify_ok), 32'd0);
        chk("rst_retry_cnt", 32'(retry_cnt), 32'd0);
        global_reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk("pwr_busy", 32'(busy), 32'd0);
        chk("pwr_adr_latch", 32'(adr_latch), 32'd1);
        chk("pwr_serial_clock", 32'(serial_clock), 32'd0);

        // autostart, loopback delayed one clock, verify_dly=1
        oe = 8'($urandom); delay = $urandom; lb_d = 1; verify_dly = 2'd1; fault = 0;
        push_expect(0, 0);
        power_up = 1'b1; vme_ready = 1'b1;
        wait_done();
        chk("auto_busy", 32'(busy), 32'd0);
        autostart_en = 1'b0;
        repeat (3) @(posedge clock);

        // fixed frame pattern 1111 1010 x4 per chip
        run_cycle(8'hFF, 32'hAAAA_AAAA, 0, 0, 0, 1'b0);
        // stuck-at-0 readback, two retries
        run_cycle(8'h5A | 8'h01, $urandom, 2, 1, 2, 1'b0);
        // single corruption on the first attempt only
        run_cycle(8'($urandom), $urandom, 1, 2, 1, 1'b0);
        // randomized clean cycles
        for (int r = 0; r < 4; r++)
            run_cycle(8'($urandom), $urandom, int'($urandom_range(0, 3)), 0,
                      int'($urandom_range(0, 3)), 1'b0);

        // reset mid-write at bit 17
        oe = 8'($urandom); delay = $urandom; lb_d = 1; verify_dly = 2'd1; fault = 0;
        push_expect(0, 0);
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        for (i = 0; i < 1000 && vrise < 17; i++) @(posedge clock);
        #1;
        chk("reach_bit17", 32'(vrise), 32'd17);
        global_reset = 1'b1;
        @(posedge clock); #1;
        chk("mid_rst_serial_clock", 32'(serial_clock), 32'd0);
        chk("mid_rst_adr_latch", 32'(adr_latch), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        global_reset = 1'b0;
        exp_bit_q.delete();
        exp_stat_q.delete();
        repeat (12) @(posedge clock);
        run_cycle(8'($urandom), $urandom, 3, 0, 0, 1'b0);

        // start held high through completion
        run_cycle(8'($urandom), $urandom, 1, 0, 0, 1'b1);
        for (i = 0; i < 2000 && exp_bit_q.size() != 0; i++) @(posedge clock);
        repeat (20) @(posedge clock);
        #1;
        chk("held_busy", 32'(busy), 32'd1);
        chk("held_verify_ok", 32'(verify_ok), 32'd1);
        chk("held_pending", 32'(exp_stat_q.size()), 32'd1);
        start = 1'b0;
        wait_done();
        chk("released_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clock);
        run_cycle(8'($urandom), $urandom, 0, 0, 1, 1'b0);

        repeat (10) @(posedge clock);
        chk("final_queue", 32'(exp_bit_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
